// File: rtl/timer_phase_seq.sv
// timer_phase_seq
//   Multi-phase timing sequencer. One shared terminal-count counter is
//   compared against a per-phase limit. Phase i lasts limit[i]+1 cycles.
//   The sequence either wraps from the last phase back to phase 0 (loop_en=1)
//   or ends in IDLE (loop_en=0).
//
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active-high; also clears all limits
//   start      in   begin at phase 0; honoured only in IDLE
//   stop       in   abort to IDLE; beats start and terminal count
//   loop_en    in   wrap from the last phase to phase 0; sampled at the last term
//   cfg_we     in   write cfg_limit into limit[cfg_idx]; legal in any state
//   cfg_idx    in   phase limit register index
//   cfg_limit  in   phase limit value
//   busy       out  sequence running
//   phase      out  current phase index
//   cnt_out    out  current in-phase count
//   phase_tick out  last cycle of any phase
//   done       out  last cycle of a one-shot sequence

module timer_phase_seq #(
    parameter int unsigned WIDTH  = 25,
    parameter int unsigned NPHASE = 4,
    parameter int unsigned PW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic             cfg_we,
    input  logic [PW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_limit,
    output logic             busy,
    output logic [PW-1:0]    phase,
    output logic [WIDTH-1:0] cnt_out,
    output logic             phase_tick,
    output logic             done
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] limit_q [NPHASE];
    logic [WIDTH-1:0] limit_d [NPHASE];

    logic term;
    logic last_phase;

    // >= rather than == so a limit lowered below the running count ends the
    // phase immediately instead of waiting for the counter to wrap.
    assign term       = (state_q == StRun) && (cnt_q >= limit_q[phase_q]);
    assign last_phase = (phase_q == PW'(NPHASE - 1));

    assign busy       = (state_q == StRun);
    assign phase      = phase_q;
    assign cnt_out    = cnt_q;
    assign phase_tick = term;
    assign done       = term && last_phase && !loop_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        limit_d = limit_q;

        if (cfg_we && (32'(cfg_idx) < NPHASE)) begin
            limit_d[cfg_idx] = cfg_limit;
        end

        if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
            phase_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    phase_d = '0;
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!term) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end else begin
                        cnt_d = '0;
                        if (last_phase) begin
                            phase_d = '0;
                            if (!loop_en) begin
                                state_d = StIdle;
                            end
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            phase_q <= '0;
            for (int i = 0; i < int'(NPHASE); i++) begin
                limit_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            limit_q <= limit_d;
        end
    end

endmodule
